mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM stage behind the EX-stage ALU. Takes the ALU result as an effective address
//  (or as a pass-through value) and runs byte/half/word loads and stores on a
//  ready-handshaked data memory. Stalls the pipeline while an access is in flight
//  and delivers a registered, sign/zero-extended write-back value.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max BUSY cycles without dmem_ready before a bus-timeout exception (>=2)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  in_valid       in   1   EX/MEM slot holds an instruction this cycle
//  alu_result     in   32  ALU output: address for ld/st, value otherwise
//  mem_read       in   1   load
//  mem_write      in   1   store (mem_read & mem_write both 1 -> illegal)
//  funct3         in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  store_data     in   32  rs2 value for stores
//  rd_in          in   5   destination register
//  reg_write_in   in   1   instruction writes rd
//  dmem_req       out  1   access request, held until dmem_ready
//  dmem_we        out  1   1 = write
//  dmem_addr      out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_be        out  4   byte enables
//  dmem_ready     in   1   access complete; dmem_rdata valid on reads
//  dmem_rdata     in   32  read word
//  stall          out  1   hold upstream stages
//  result         out  32  write-back value (registered)
//  result_valid   out  1   one-cycle pulse: result/rd_out/reg_write_out valid
//  rd_out         out  5   registered rd_in
//  reg_write_out  out  1   registered reg_write_in, forced 0 on exception
//  exc            out  1   one-cycle exception pulse
//  exc_cause      out  2   00 none, 01 misaligned, 10 illegal op/funct3, 11 bus timeout
// BEHAVIOUR
//  - Reset (async, any state incl. BUSY): state=IDLE, every output 0, counter 0;
//    dmem_req drops at once, pending access abandoned.
//  - FSM IDLE/BUSY. IDLE + in_valid + no memory op: next edge result=alu_result,
//    result_valid=1; latency 1, stall 0.
//  - IDLE + in_valid + ld/st: check alignment (H: addr[0]=0; W: addr[1:0]=0;
//    B always ok) and funct3 (store: 000/001/010; load: 000/001/010/100/101).
//    * Bad: no request; next edge exc=1, cause 01/10, result_valid=1,
//      reg_write_out=0; stall stays 0.
//    * Good: stall=1 combinationally this cycle; next edge capture
//      addr/funct3/data/rd and go BUSY.
//  - BUSY: dmem_req=1. dmem_we/addr/wdata/be come from registers and hold until
//    ready. stall = !dmem_ready. in_valid is ignored.
//  - Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}; SH be=addr[1]?1100:0011,
//    wdata={2{d[15:0]}}; SW be=1111, wdata=d. Loads: be=1111, we=0.
//  - BUSY + dmem_ready: next edge IDLE and result_valid=1. Loads: result = rdata
//    lane at addr[1:0] (byte) or addr[1] (half); sign-extend for B/H, zero-extend
//    for BU/HU. Stores: result=0 and reg_write_out=0. Min access = 2 cycles
//    (accept + 1 BUSY).
//  - Timeout: counter clears on BUSY entry and counts BUSY cycles. When it reaches
//    TIMEOUT_CYCLES with no ready: exc=1, cause=11, result_valid=1,
//    reg_write_out=0, return to IDLE, stall 0. dmem_ready in the same cycle as
//    expiry wins (normal completion).
//  - exc and result_valid pulse exactly one cycle. In the cycle after completion
//    (IDLE), a new in_valid is accepted at once.
// TESTING
//  1 Pass-through: alu_result=32'h1234_5678, no mem op, rd=5 -> 1 cycle later
//    result=h12345678, rd_out=5, valid pulse, stall never 1.
//  2 LB at addr h103, rdata=h80FF_0000, ready after 3 BUSY cycles -> result=hFFFF_FF80,
//    stall high 3 cycles; LBU same -> h0000_0080; LH addr h102 -> hFFFF_80FF.
//  3 SH addr h206, data hAAAA_BEEF -> be=1100, wdata=hBEEF_BEEF, addr=h204,
//    reg_write_out=0.
//  4 LW addr h101 -> no dmem_req, exc=1 cause 01; funct3=011 load -> cause 10.
//  5 dmem_ready never asserted -> exc cause 11 after exactly 16 BUSY cycles; ready on
//    cycle 16 -> normal completion, no exc.
//  6 rst_n low mid-BUSY -> dmem_req, stall, outputs 0 immediately; next load after
//    release completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM stage behind the EX-stage ALU: byte/half/word loads and stores on a
// ready-handshaked data memory. The pipeline is held while an access is in
// flight; the write-back value is registered and sign/zero-extended.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] result,
    output logic        result_valid,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        exc,
    output logic [1:0]  exc_cause
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       addr_lo;
    logic [2:0]       f3_q;
    logic             load_q;
    logic [4:0]       rd_q;
    logic             rw_q;

    logic mem_op;
    logic bad_op;
    logic misalign;
    logic accept;

    // Byte enables for a store: lane(s) selected by the low address bits.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << a;
            2'b01:   store_be = a[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Store data replicated across lanes so the enabled lane carries it.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_wdata = {4{d[7:0]}};
            2'b01:   store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

    // Pick the addressed lane of the read word and extend it to 32 bits.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    // Decode of the incoming slot: legality, alignment and acceptance.
    always_comb begin
        mem_op   = mem_read | mem_write;
        bad_op   = 1'b0;
        misalign = 1'b0;
        if (mem_read && mem_write) begin
            bad_op = 1'b1;
        end else if (mem_read) begin
            bad_op = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else if (mem_write) begin
            bad_op = !(funct3 inside {3'b000, 3'b001, 3'b010});
        end
        case (funct3[1:0])
            2'b01:   misalign = alu_result[0];
            2'b10:   misalign = |alu_result[1:0];
            default: misalign = 1'b0;
        endcase
        accept = (state == IDLE) && in_valid && mem_op && !bad_op && !misalign;
    end

    // Request is live for the whole BUSY period; stall covers accept and waiting.
    always_comb begin
        dmem_req = (state == BUSY);
        stall    = rst_n && (accept || ((state == BUSY) && !dmem_ready));
    end

    // Access FSM with registered bus signals and write-back outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            addr_lo       <= 2'b00;
            f3_q          <= 3'b000;
            load_q        <= 1'b0;
            rd_q          <= 5'd0;
            rw_q          <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'd0;
            dmem_wdata    <= 32'd0;
            dmem_be       <= 4'd0;
            result        <= 32'd0;
            result_valid  <= 1'b0;
            rd_out        <= 5'd0;
            reg_write_out <= 1'b0;
            exc           <= 1'b0;
            exc_cause     <= 2'b00;
        end else begin
            result_valid <= 1'b0;
            exc          <= 1'b0;
            exc_cause    <= 2'b00;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!mem_op) begin
                            result        <= alu_result;
                            result_valid  <= 1'b1;
                            rd_out        <= rd_in;
                            reg_write_out <= reg_write_in;
                        end else if (bad_op || misalign) begin
                            exc           <= 1'b1;
                            exc_cause     <= bad_op ? 2'b10 : 2'b01;
                            result        <= 32'd0;
                            result_valid  <= 1'b1;
                            rd_out        <= rd_in;
                            reg_write_out <= 1'b0;
                        end else begin
                            state      <= BUSY;
                            cnt        <= '0;
                            addr_lo    <= alu_result[1:0];
                            f3_q       <= funct3;
                            load_q     <= mem_read;
                            rd_q       <= rd_in;
                            rw_q       <= reg_write_in;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {alu_result[31:2], 2'b00};
                            dmem_be    <= mem_write ? store_be(funct3, alu_result[1:0]) : 4'b1111;
                            dmem_wdata <= mem_write ? store_wdata(funct3, store_data) : 32'd0;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        state         <= IDLE;
                        result        <= load_q ? load_ext(dmem_rdata, addr_lo, f3_q) : 32'd0;
                        result_valid  <= 1'b1;
                        rd_out        <= rd_q;
                        reg_write_out <= load_q && rw_q;
                    end else if (cnt == CNT_LAST) begin
                        state         <= IDLE;
                        exc           <= 1'b1;
                        exc_cause     <= 2'b11;
                        result        <= 32'd0;
                        result_valid  <= 1'b1;
                        rd_out        <= rd_q;
                        reg_write_out <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: single-cycle vector table plus
// hand-written multi-cycle access, timeout and reset sequences.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] alu_result;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        exc;
    logic [1:0]  exc_cause;

    int tests;
    int fails;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_result(alu_result),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .store_data(store_data), .rd_in(rd_in), .reg_write_in(reg_write_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall(stall), .result(result),
        .result_valid(result_valid), .rd_out(rd_out), .reg_write_out(reg_write_out),
        .exc(exc), .exc_cause(exc_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       nm;
        logic [31:0] alu;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [4:0]  rdi;
        logic        rwi;
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic        e_exc;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t vecs[9];

    // One memory access: drives the slot, answers the bus after ready_at BUSY
    // cycles (0 = never) and checks lanes, stall count, latency and write-back.
    task automatic mem_access(input string nm, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int ready_at, input int exp_busy, input int exp_stall,
                              input logic [31:0] exp_res, input logic exp_rw,
                              input logic [1:0] exp_cause, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
        int  stalls;
        int  busy;
        bit  done;
        @(negedge clk);
        in_valid = 1'b1; alu_result = addr; mem_read = rd; mem_write = wr;
        funct3 = f3; store_data = sdata; rd_in = 5'd7; reg_write_in = 1'b1;
        dmem_ready = 1'b0; dmem_rdata = rdata;
        stalls = 0; busy = 0; done = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (stall) stalls++;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (result_valid) begin
                done = 1;
                dmem_ready = 1'b0;
                chk({nm, " result"}, result, exp_res);
                chk({nm, " rd_out"}, {27'd0, rd_out}, 32'd7);
                chk({nm, " reg_write_out"}, {31'd0, reg_write_out}, {31'd0, exp_rw});
                chk({nm, " exc"}, {31'd0, exc}, {31'd0, exp_cause != 2'b00});
                chk({nm, " exc_cause"}, {30'd0, exc_cause}, {30'd0, exp_cause});
                chk({nm, " busy cycles"}, busy, exp_busy);
                chk({nm, " stall cycles"}, stalls, exp_stall);
                chk({nm, " req after done"}, {31'd0, dmem_req}, 32'd0);
            end else if (dmem_req) begin
                busy++;
                if (busy == 1) begin
                    chk({nm, " we"}, {31'd0, dmem_we}, {31'd0, wr});
                    chk({nm, " addr"}, dmem_addr, exp_addr);
                    chk({nm, " be"}, {28'd0, dmem_be}, {28'd0, exp_be});
                    if (wr) chk({nm, " wdata"}, dmem_wdata, exp_wdata);
                end
                dmem_ready = (busy == ready_at);
            end
        end
        if (!done) chk({nm, " completion within budget"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        chk({nm, " valid pulse width"}, {31'd0, result_valid}, 32'd0);
        chk({nm, " exc pulse width"}, {31'd0, exc}, 32'd0);
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = '0; store_data = '0; rd_in = '0; reg_write_in = 1'b0;
        dmem_ready = 1'b0; dmem_rdata = '0;

        vecs[0] = '{"pass 12345678", 32'h1234_5678, 0, 0, 3'b000, 5'd5, 1, 32'h1234_5678, 5'd5, 1, 0, 2'b00};
        vecs[1] = '{"pass rw0",      32'hDEAD_0001, 0, 0, 3'b010, 5'd9, 0, 32'hDEAD_0001, 5'd9, 0, 0, 2'b00};
        vecs[2] = '{"LW misalign",   32'h0000_0101, 1, 0, 3'b010, 5'd3, 1, 32'd0, 5'd3, 0, 1, 2'b01};
        vecs[3] = '{"load f3 011",   32'h0000_0100, 1, 0, 3'b011, 5'd4, 1, 32'd0, 5'd4, 0, 1, 2'b10};
        vecs[4] = '{"LH misalign",   32'h0000_0101, 1, 0, 3'b001, 5'd6, 1, 32'd0, 5'd6, 0, 1, 2'b01};
        vecs[5] = '{"SW misalign",   32'h0000_0102, 0, 1, 3'b010, 5'd8, 0, 32'd0, 5'd8, 0, 1, 2'b01};
        vecs[6] = '{"store f3 100",  32'h0000_0100, 0, 1, 3'b100, 5'd2, 0, 32'd0, 5'd2, 0, 1, 2'b10};
        vecs[7] = '{"rd and wr",     32'h0000_0100, 1, 1, 3'b010, 5'd1, 1, 32'd0, 5'd1, 0, 1, 2'b10};
        vecs[8] = '{"LHU misalign",  32'h0000_0103, 1, 0, 3'b101, 5'd11, 1, 32'd0, 5'd11, 0, 1, 2'b01};

        // Reset state
        #12;
        chk("reset result", result, 32'd0);
        chk("reset valid", {31'd0, result_valid}, 32'd0);
        chk("reset req", {31'd0, dmem_req}, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset be", {28'd0, dmem_be}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle vectors
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1; alu_result = vecs[i].alu; mem_read = vecs[i].rd;
            mem_write = vecs[i].wr; funct3 = vecs[i].f3; rd_in = vecs[i].rdi;
            reg_write_in = vecs[i].rwi; store_data = 32'h5555_AAAA;
            #1;
            chk({vecs[i].nm, " stall"}, {31'd0, stall}, 32'd0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk({vecs[i].nm, " req"}, {31'd0, dmem_req}, 32'd0);
            chk({vecs[i].nm, " valid"}, {31'd0, result_valid}, 32'd1);
            chk({vecs[i].nm, " result"}, result, vecs[i].e_res);
            chk({vecs[i].nm, " rd_out"}, {27'd0, rd_out}, {27'd0, vecs[i].e_rd});
            chk({vecs[i].nm, " rw_out"}, {31'd0, reg_write_out}, {31'd0, vecs[i].e_rw});
            chk({vecs[i].nm, " exc"}, {31'd0, exc}, {31'd0, vecs[i].e_exc});
            chk({vecs[i].nm, " cause"}, {30'd0, exc_cause}, {30'd0, vecs[i].e_cause});
        end
        @(posedge clk);
        #1;
        chk("vec valid pulse width", {31'd0, result_valid}, 32'd0);

        // Loads and stores
        mem_access("LB",  1, 0, 3'b000, 32'h103, 0, 32'h80FF_0000, 3, 3, 3,  32'hFFFF_FF80, 1, 2'b00, 4'b1111, 0, 32'h100);
        mem_access("LBU", 1, 0, 3'b100, 32'h103, 0, 32'h80FF_0000, 3, 3, 3,  32'h0000_0080, 1, 2'b00, 4'b1111, 0, 32'h100);
        mem_access("LH",  1, 0, 3'b001, 32'h102, 0, 32'h80FF_0000, 2, 2, 2,  32'hFFFF_80FF, 1, 2'b00, 4'b1111, 0, 32'h100);
        mem_access("LHU", 1, 0, 3'b101, 32'h102, 0, 32'h80FF_0000, 1, 1, 1,  32'h0000_80FF, 1, 2'b00, 4'b1111, 0, 32'h100);
        mem_access("LW",  1, 0, 3'b010, 32'h104, 0, 32'h80FF_0000, 1, 1, 1,  32'h80FF_0000, 1, 2'b00, 4'b1111, 0, 32'h104);
        mem_access("LB0", 1, 0, 3'b000, 32'h100, 0, 32'h1234_567F, 1, 1, 1,  32'h0000_007F, 1, 2'b00, 4'b1111, 0, 32'h100);
        mem_access("SH",  0, 1, 3'b001, 32'h206, 32'hAAAA_BEEF, 0, 2, 2, 2, 32'd0, 0, 2'b00, 4'b1100, 32'hBEEF_BEEF, 32'h204);
        mem_access("SHlo",0, 1, 3'b001, 32'h200, 32'hAAAA_BEEF, 0, 1, 1, 1, 32'd0, 0, 2'b00, 4'b0011, 32'hBEEF_BEEF, 32'h200);
        mem_access("SB",  0, 1, 3'b000, 32'h201, 32'h1234_5678, 0, 1, 1, 1, 32'd0, 0, 2'b00, 4'b0010, 32'h7878_7878, 32'h200);
        mem_access("SW",  0, 1, 3'b010, 32'h300, 32'hCAFE_F00D, 0, 1, 1, 1, 32'd0, 0, 2'b00, 4'b1111, 32'hCAFE_F00D, 32'h300);

        // Timeout boundary: never ready vs ready in the expiry cycle
        mem_access("TO",  1, 0, 3'b010, 32'h400, 0, 32'h1111_2222, 0, 16, 17, 32'd0, 0, 2'b11, 4'b1111, 0, 32'h400);
        mem_access("RDY16", 1, 0, 3'b010, 32'h400, 0, 32'h1111_2222, 16, 16, 16, 32'h1111_2222, 1, 2'b00, 4'b1111, 0, 32'h400);

        // Asynchronous reset in the middle of a BUSY period
        @(negedge clk);
        in_valid = 1'b1; alu_result = 32'h500; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = 3'b010; rd_in = 5'd7; reg_write_in = 1'b1; dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("rst seq req before", {31'd0, dmem_req}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst mid req", {31'd0, dmem_req}, 32'd0);
        chk("rst mid stall", {31'd0, stall}, 32'd0);
        chk("rst mid addr", dmem_addr, 32'd0);
        chk("rst mid be", {28'd0, dmem_be}, 32'd0);
        chk("rst mid result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_access("post-rst LW", 1, 0, 3'b010, 32'h508, 0, 32'h0BAD_F00D, 2, 2, 2, 32'h0BAD_F00D, 1, 2'b00, 4'b1111, 0, 32'h508);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
